bus_master_initiator: RTL

- 68000-style bus cycle initiator. The FPGA uses it to take the CPU bus and run single word/byte read or write cycles against PROM/SRAM/IO, for example for monitor-driven memory load and inspect.
- Sequence per transfer: arbitrates with the CPU via BR/BG/BGACK, drives AS/UDS/LDS/RW/address/data, then waits for DTACK or BERR from the bus responder.
- Sits between the monitor command path and the shared CPU bus pins, in the MCLK_IN domain.

---
 rtl/bus_master_initiator.sv | 116 +++++++++++
 1 files changed

// File: rtl/bus_master_initiator.sv
// bus_master_initiator: 68000-style single-transfer bus master (BR/BG/BGACK arbitration, AS/UDS/LDS cycle).
// Define BUS_TIMEOUT_EN to abort on a missing grant or acknowledge after TIMEOUT_CYCLES.
module bus_master_initiator #(
  parameter int SETUP_CYCLES   = 1,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        MCLK_IN,
  input  logic        RESET_n_IN,
  input  logic        REQ_IN,
  input  logic        REQ_WR_IN,
  input  logic        REQ_UDS_IN,
  input  logic        REQ_LDS_IN,
  input  logic [23:0] REQ_ADDR_IN,
  input  logic [15:0] REQ_WDATA_IN,
  input  logic        BG_IN,
  input  logic        CPU_AS_IN,
  input  logic        DTACK_IN,
  input  logic        BERR_IN,
  input  logic [15:0] DATA_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [15:0] RDATA,
  output logic        BUS_REQUEST,
  output logic        BUS_GRANT_ACK,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        WR,
  output logic [23:0] ADDR,
  output logic        ADDR_OE,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE
);
  typedef enum logic [2:0] {IDLE, REQUEST, SETUP, STROBE, WAITACK, RELEASE, FINISH} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic wr, uds, lds, err, ill, to, own, strb;
  logic [23:0] addr;
  logic [15:0] wdata;
  assign ill = !REQ_UDS_IN && !REQ_LDS_IN;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo;
  assign to = tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge MCLK_IN)
    tmo <= (!RESET_n_IN || state != nxt) ? '0 : tmo + 1'b1;
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge MCLK_IN)
    state <= !RESET_n_IN ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = REQ_IN ? (ill ? FINISH : REQUEST) : IDLE;
      REQUEST: nxt = (BG_IN && !CPU_AS_IN) ? SETUP : (to ? FINISH : REQUEST);
      SETUP:   nxt = cnt == 4'(SETUP_CYCLES - 1) ? STROBE : SETUP;
      STROBE:  nxt = (!wr || cnt == 4'd1) ? WAITACK : STROBE;
      WAITACK: nxt = (BERR_IN || DTACK_IN || to) ? RELEASE : WAITACK;
      RELEASE: nxt = cnt == 4'(HOLD_CYCLES - 1) ? FINISH : RELEASE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge MCLK_IN) begin
    if (!RESET_n_IN) begin
      cnt   <= '0;
      wr    <= 1'b0;
      uds   <= 1'b0;
      lds   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      err   <= 1'b0;
      RDATA <= '0;
    end else begin
      cnt <= state != nxt ? '0 : cnt + 4'd1;
      if (state == IDLE && REQ_IN) begin
        wr    <= REQ_WR_IN;
        uds   <= REQ_UDS_IN;
        lds   <= REQ_LDS_IN;
        addr  <= REQ_ADDR_IN;
        wdata <= REQ_WDATA_IN;
        err   <= ill;
      end
      if (state == REQUEST && nxt == FINISH)
        err <= 1'b1;
      // BERR has priority; a read captures data only on a clean DTACK
      if (state == WAITACK) begin
        if (BERR_IN)
          err <= 1'b1;
        else if (DTACK_IN)
          RDATA <= wr ? RDATA : DATA_IN;
        else if (to)
          err <= 1'b1;
      end
    end
  end
  always_comb begin
    own           = state inside {SETUP, STROBE, WAITACK, RELEASE};
    strb          = state == WAITACK || (state == STROBE && (!wr || cnt == 4'd1));
    BUSY          = state != IDLE && state != FINISH;
    DONE          = state == FINISH;
    ERROR         = DONE && err;
    BUS_REQUEST   = state == REQUEST;
    BUS_GRANT_ACK = own;
    ADDR_OE       = own;
    DATA_OE       = own && wr;
    WR            = own && wr;
    AS            = state == STROBE || state == WAITACK;
    UDS           = strb && uds;
    LDS           = strb && lds;
    ADDR          = own ? (addr & 24'hFFFFFE) : '0;
    DATA_OUT      = (own && wr) ? wdata : '0;
  end
endmodule
